// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state encoding and default geometry/latency constants for data_mem_responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_WAIT_CYCLES = 2;
endpackage

// File: rtl/dmem_word_ram.sv
// dmem_word_ram: 2**ADDR_WIDTH x 32-bit RAM, sync byte-enabled write, async read (clk, we, addr, wdata, be -> rdata)
module dmem_word_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready memory responder with WAIT_CYCLES latency; req_* in (valid/ready/we/addr/wdata/be), rsp_* out (valid/ready/rdata/err)
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  state_t state, nxt;
  logic [3:0] cnt;
  logic lat_we, lat_err;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [31:0] lat_wdata;
  logic [3:0] lat_be;
  logic idle, addr_err, op_we, op_err, enter_resp;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic [31:0] op_wdata, ram_rdata;
  logic [3:0] op_be;
  assign idle = state == IDLE;
  assign addr_err = |req_addr[1:0] || |(req_addr >> (ADDR_WIDTH + 2));
  assign op_we = idle ? req_we : lat_we;
  assign op_err = idle ? addr_err : lat_err;
  assign op_idx = idle ? req_addr[ADDR_WIDTH+1:2] : lat_idx;
  assign op_wdata = idle ? req_wdata : lat_wdata;
  assign op_be = idle ? req_be : lat_be;
  assign enter_resp = nxt == RESP && state != RESP;
  assign req_ready = idle;
  assign rsp_valid = state == RESP;
  always_comb
    nxt = idle ? (req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
        : state == WAIT ? (cnt == 4'(WAIT_CYCLES - 1) ? RESP : WAIT)
        : (rsp_ready ? IDLE : RESP);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
      if (enter_resp) begin
        rsp_err <= op_err;
        rsp_rdata <= op_we || op_err ? 32'd0 : ram_rdata;
      end
    end
  always_ff @(posedge clk)
    if (idle && req_valid) begin
      lat_we <= req_we;
      lat_err <= addr_err;
      lat_idx <= req_addr[ADDR_WIDTH+1:2];
      lat_wdata <= req_wdata;
      lat_be <= req_be;
    end
  dmem_word_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .we(enter_resp && op_we && !op_err && !rst),
    .addr(op_idx),
    .wdata(op_wdata),
    .be(op_be),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a word-array model
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0] req_be;
  logic z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0] z_req_be;
  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [256];
  logic [3:0] known [256];
  data_mem_responder u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  data_mem_responder #(.WAIT_CYCLES(0)) u_zero (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );
  function automatic bit is_err(logic [31:0] a);
    return a[1:0] != 2'd0 || a >= 32'd1024;
  endfunction
  function automatic logic [31:0] known_mask(logic [31:0] a);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = known[a[9:2]][i] ? 8'hFF : 8'h00;
    return m;
  endfunction
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (!is_err(a))
      for (int i = 0; i < 4; i++)
        if (be[i]) begin
          mdl[a[9:2]][8*i +: 8] = d[8*i +: 8];
          known[a[9:2]][i] = 1'b1;
        end
  endtask
  task automatic scramble();
    req_we = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    req_be = 4'($urandom);
  endtask
  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input int hold, output logic [31:0] rd, output logic er, output int lat,
                        output bit stable, output bit idle_ok);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    req_valid = 1'b0;
    scramble();
    while (rsp_valid !== 1'b1 && lat < 40) begin
      req_valid = 1'($urandom);
      scramble();
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    stable = 1'b1;
    repeat (hold) begin
      req_valid = 1'b1;
      scramble();
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    req_valid = 1'($urandom);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    idle_ok = req_ready === 1'b1 && rsp_valid === 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    rst = 1'b0;
  endtask
  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat; bit st, io;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, io);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rd); end
    checks++; if (lat != 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, io);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
    checks++; if (lat != 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
  endtask
  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat; bit st, io;
    do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, rd, er, lat, st, io);
    model_write(32'h10, 32'h000000AA, 4'b0001);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, io);
    checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be_rdata: got %h want deadbeaa", rd); end
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, st, io);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL be0_err: got %b want 0", er); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, io);
    checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be0_rdata: got %h want deadbeaa", rd); end
  endtask
  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit st, io;
    do_req(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, 0, rd, er, lat, st, io);
    model_write(32'h0, 32'h5A5A5A5A, 4'hF);
    do_req(1'b0, 32'h11, 32'h0, 4'h0, 0, rd, er, lat, st, io);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL mis_rdata: got %h want 0", rd); end
    do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, st, io);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL oor_rdata: got %h want 0", rd); end
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, st, io);
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL oor_nowrite: got %h want 5a5a5a5a", rd); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, io);
    checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL mis_nowrite: got %h want deadbeaa", rd); end
  endtask
  task automatic test_stall();
    logic [31:0] rd; logic er; int lat; bit st, io;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, st, io);
    checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL stall_rdata: got %h want deadbeaa", rd); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b want 1", st); end
    checks++; if (io !== 1'b1) begin errors++; $display("FAIL stall_idle_after: got %b want 1", io); end
  endtask
  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; bit st, io, quiet;
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, st, io);
    model_write(32'h20, 32'h11223344, 4'hF);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got %b want 1", req_ready); end
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL midrst_quiet: got %b want 1", quiet); end
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, io);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL midrst_rdata: got %h want 11223344", rd); end
  endtask
  task automatic test_random();
    logic [31:0] rd, a, d, exp, m; logic er; int lat; bit st, io, we, eerr; logic [3:0] be;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d = $urandom;
      be = 4'($urandom);
      we = 1'($urandom);
      eerr = is_err(a);
      exp = we || eerr ? 32'd0 : mdl[a[9:2]];
      m = we || eerr ? 32'hFFFFFFFF : known_mask(a);
      do_req(we, a, d, be, $urandom_range(0, 3), rd, er, lat, st, io);
      if (we) model_write(a, d, be);
      checks++; if (er !== eerr) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b addr %h", n, er, eerr, a); end
      checks++; if ((rd & m) !== (exp & m)) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h mask %h", n, rd, exp, m); end
      checks++; if (lat != 3 || st !== 1'b1) begin errors++; $display("FAIL rand_timing[%0d]: got lat %0d stable %b want 3 1", n, lat, st); end
    end
  endtask
  task automatic test_zero_wait();
    z_rsp_ready = 1'b1;
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'h12345678; z_req_be = 4'hF;
    checks++; if (z_req_ready !== 1'b1) begin errors++; $display("FAIL zw_ready0: got %b want 1", z_req_ready); end
    @(negedge clk);
    checks++; if (z_rsp_valid !== 1'b1) begin errors++; $display("FAIL zw_valid1: got %b want 1", z_rsp_valid); end
    checks++; if (z_req_ready !== 1'b0) begin errors++; $display("FAIL zw_ready1: got %b want 0", z_req_ready); end
    z_req_we = 1'b0;
    @(negedge clk);
    checks++; if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin errors++; $display("FAIL zw_second_accept: got ready %b valid %b want 1 0", z_req_ready, z_rsp_valid); end
    @(negedge clk);
    z_req_valid = 1'b0;
    checks++; if (z_rsp_valid !== 1'b1) begin errors++; $display("FAIL zw_valid3: got %b want 1", z_rsp_valid); end
    checks++; if (z_rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL zw_rdata: got %h want 12345678", z_rsp_rdata); end
    @(negedge clk);
    checks++; if (z_rsp_valid !== 1'b0) begin errors++; $display("FAIL zw_done: got %b want 0", z_rsp_valid); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    foreach (known[i]) known[i] = 4'h0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0; z_req_be = 4'd0; z_rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_stall();
    test_reset_mid();
    test_random();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
